// File: rtl/instr_mem_loader.sv
// Boot loader: packs a host byte stream into 32-bit words, writes them to the instruction
// memory from address 0, reads them back against a running checksum, then releases the CPU.
module instr_mem_loader #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata,
   output logic              mem_clken,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_reset_req,
   output logic [31:0]       checksum
);

   typedef enum logic [2:0] {StIdle, StLoad, StVerify, StDone, StError} state_e;

   localparam logic [ADDR_W:0] MaxWords = (ADDR_W+1)'(DEPTH);

   state_e          state;
   logic [ADDR_W:0] num_words;
   logic [ADDR_W:0] word_idx;
   logic [ADDR_W:0] vcnt;
   logic [1:0]      byte_cnt;
   logic [23:0]     pack;
   logic            load_last;
   logic [31:0]     verify_sum;

   logic            accept;
   logic [ADDR_W:0] last_idx;

   assign accept         = in_valid & in_ready;
   assign last_idx       = num_words - 1'b1;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= StIdle;
         in_ready       <= 1'b0;
         mem_address    <= '0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         cpu_reset_req  <= 1'b1;
         checksum       <= '0;
         num_words      <= '0;
         word_idx       <= '0;
         vcnt           <= '0;
         byte_cnt       <= '0;
         pack           <= '0;
         load_last      <= 1'b0;
         verify_sum     <= '0;
      end else begin
         unique case (state)
            StIdle, StDone, StError: begin
               if (start) begin
                  cpu_reset_req <= 1'b1;
                  done          <= 1'b0;
                  if (word_count == '0 || word_count > MaxWords) begin
                     state <= StError;
                     error <= 1'b1;
                  end else begin
                     state     <= StLoad;
                     num_words <= word_count;
                     checksum  <= '0;
                     byte_cnt  <= '0;
                     word_idx  <= '0;
                     load_last <= 1'b0;
                     error     <= 1'b0;
                     busy      <= 1'b1;
                     in_ready  <= 1'b1;
                  end
               end
            end
            StLoad: begin
               mem_chipselect <= 1'b0;
               mem_write      <= 1'b0;
               if (load_last) begin
                  // The last word's write cycle is over: issue the first readback.
                  state          <= StVerify;
                  mem_chipselect <= 1'b1;
                  mem_address    <= '0;
                  vcnt           <= '0;
                  verify_sum     <= '0;
               end else if (accept) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  unique case (byte_cnt)
                     2'd0: pack[7:0]   <= in_data;
                     2'd1: pack[15:8]  <= in_data;
                     2'd2: pack[23:16] <= in_data;
                     2'd3: begin
                        mem_chipselect <= 1'b1;
                        mem_write      <= 1'b1;
                        mem_writedata  <= {in_data, pack};
                        mem_address    <= word_idx[ADDR_W-1:0];
                        checksum       <= checksum + {in_data, pack};
                        word_idx       <= word_idx + 1'b1;
                        if (word_idx == last_idx) begin
                           load_last <= 1'b1;
                           in_ready  <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            StVerify: begin
               vcnt <= vcnt + 1'b1;
               if (vcnt < last_idx) begin
                  mem_address <= mem_address + 1'b1;
               end else begin
                  mem_chipselect <= 1'b0;
               end
               // Read data trails its address by one cycle.
               if (vcnt != '0 && vcnt <= num_words) begin
                  verify_sum <= verify_sum + mem_readdata;
               end
               if (vcnt == num_words + 1'b1) begin
                  busy <= 1'b0;
                  if (verify_sum == checksum) begin
                     state         <= StDone;
                     done          <= 1'b1;
                     cpu_reset_req <= 1'b0;
                  end else begin
                     state <= StError;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader with a behavioural memory and reference model.
module tb_instr_mem_loader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [10:0] word_count;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  mem_address;
   logic        mem_chipselect;
   logic        mem_write;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_clken;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_reset_req;
   logic [31:0] checksum;

   instr_mem_loader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .word_count     (word_count),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_writedata  (mem_writedata),
      .mem_readdata   (mem_readdata),
      .mem_clken      (mem_clken),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .cpu_reset_req  (cpu_reset_req),
      .checksum       (checksum)
   );

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_wr_cyc = 0;
   int          rd_count = 0;
   int          rd_next = 0;
   int          corrupt_addr = -1;
   int          first_acc = 0;
   int          last_acc = 0;
   int          stalls = 0;
   wr_t         exp_q[$];
   logic [7:0]  byte_q[$];
   logic [31:0] mem[1024];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory with registered read; optionally returns 0 for one corrupted address.
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) mem[mem_address] <= mem_writedata;
         else mem_readdata <= (int'(mem_address) == corrupt_addr) ? 32'h0 : mem[mem_address];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every write pops the scoreboard; every read must walk 0,1,2,...
   always @(negedge clk) begin
      wr_t e;
      if (reset_n) begin
         if (mem_chipselect && mem_write) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual addr=%0d data=%h required none",
                        mem_address, mem_writedata);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 64'(mem_address), 64'(e.addr));
               check("wr_data", 64'(mem_writedata), 64'(e.data));
               check("wr_cycle", 64'(cyc), 64'(e.cyc));
               check("wr_byteenable", 64'(mem_byteenable), 64'hF);
            end
            last_wr_cyc = cyc;
         end else if (mem_chipselect) begin
            check("rd_addr", 64'(mem_address), 64'(rd_next));
            rd_next++;
            rd_count++;
         end
      end
   end

   // Entered and left at posedge+1. Bytes come from byte_q (4*n of them).
   task automatic run_load(input int n, input int valid_pct, input bit expect_ok);
      logic [31:0] words[$];
      logic [31:0] sum;
      int          idx;
      int          budget;
      bit          tmo;
      sum = 0;
      for (int w = 0; w < n; w++) begin
         words.push_back({byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]});
         sum = sum + words[w];
      end
      rd_count = 0;
      rd_next  = 0;
      stalls   = 0;
      start      = 1'b1;
      word_count = 11'(n);
      @(posedge clk);
      #1 start = 1'b0;
      check("load_busy", 64'(busy), 64'd1);
      check("load_in_ready", 64'(in_ready), 64'd1);
      check("load_cpu_reset_req", 64'(cpu_reset_req), 64'd1);
      check("load_done_clr", 64'(done), 64'd0);
      idx = 0;
      budget = 0;
      while (idx < 4 * n && budget < 40 * n + 100) begin
         in_valid = ($urandom_range(99) < valid_pct);
         in_data  = byte_q[idx];
         @(negedge clk);
         if (in_valid && in_ready) begin
            if (idx % 4 == 3) exp_q.push_back('{addr: idx / 4, data: words[idx / 4], cyc: cyc + 1});
            if (idx == 0) first_acc = cyc;
            last_acc = cyc;
            idx++;
         end else if (in_valid) begin
            stalls++;
         end
         budget++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("bytes_accepted", 64'(idx), 64'(4 * n));
      tmo = 1'b1;
      for (int k = 0; k < n + 40; k++) begin
         @(negedge clk);
         if (done || error) begin
            tmo = 1'b0;
            break;
         end
      end
      if (tmo) begin
         checks++;
         errors++;
         $display("FAIL load_timeout actual=busy required=done_or_error");
      end else begin
         check("end_done", 64'(done), 64'(expect_ok));
         check("end_error", 64'(error), 64'(!expect_ok));
         check("end_cpu_reset_req", 64'(cpu_reset_req), 64'(!expect_ok));
         check("end_busy", 64'(busy), 64'd0);
         check("end_checksum", 64'(checksum), 64'(sum));
         check("verify_cycles", 64'(cyc - last_wr_cyc - 1), 64'(n + 2));
         check("read_count", 64'(rd_count), 64'(n));
         check("writes_left", 64'(exp_q.size()), 64'd0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic bad_start(input int n);
      rd_count = 0;
      start      = 1'b1;
      word_count = 11'(n);
      @(posedge clk);
      #1 start = 1'b0;
      check("bad_error", 64'(error), 64'd1);
      check("bad_busy", 64'(busy), 64'd0);
      check("bad_in_ready", 64'(in_ready), 64'd0);
      check("bad_cpu_reset_req", 64'(cpu_reset_req), 64'd1);
      check("bad_done", 64'(done), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("bad_no_access", 64'(mem_chipselect), 64'd0);
      check("bad_no_reads", 64'(rd_count), 64'd0);
   endtask

   task automatic fill_random(input int n);
      byte_q.delete();
      for (int i = 0; i < 4 * n; i++) byte_q.push_back(8'($urandom));
   endtask

   task automatic fill_directed();
      logic [63:0] pat;
      pat = 64'hDEAD_BEEF_1234_5678;
      byte_q.delete();
      for (int i = 0; i < 8; i++) byte_q.push_back(pat[8*i +: 8]);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      word_count = '0;
      in_data    = '0;
      in_valid   = 1'b0;
      #12 reset_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (5) @(posedge clk);
      #1;
      check("rst_cpu_reset_req", 64'(cpu_reset_req), 64'd1);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done_error", 64'({done, error}), 64'd0);
      check("rst_mem_address", 64'(mem_address), 64'd0);
      check("rst_checksum", 64'(checksum), 64'd0);
      check("rst_clken", 64'(mem_clken), 64'd1);
      in_valid = 1'b0;

      fill_directed();
      run_load(2, 100, 1'b1);
      check("dir_checksum", 64'(checksum), 64'hF0E2_1567);

      bad_start(0);
      bad_start(1025);

      corrupt_addr = 1;
      fill_directed();
      run_load(2, 70, 1'b0);
      corrupt_addr = -1;

      for (int t = 0; t < 6; t++) begin
         int n;
         n = $urandom_range(40, 1);
         fill_random(n);
         run_load(n, $urandom_range(100, 30), 1'b1);
      end

      fill_random(1024);
      run_load(1024, 100, 1'b1);
      check("full_consecutive", 64'(last_acc - first_acc), 64'd4095);
      check("full_no_stall", 64'(stalls), 64'd0);
      check("full_last_addr", 64'(mem_address), 64'd1023);

      // Abort a load after 5 bytes with an asynchronous reset.
      fill_random(3);
      start      = 1'b1;
      word_count = 11'd3;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = byte_q[i];
         @(negedge clk);
         if (i == 3) exp_q.push_back('{addr: 0,
                                       data: {byte_q[3], byte_q[2], byte_q[1], byte_q[0]},
                                       cyc: cyc + 1});
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd0);
      check("abort_cpu_reset_req", 64'(cpu_reset_req), 64'd1);
      check("abort_chipselect", 64'(mem_chipselect), 64'd0);
      check("abort_checksum", 64'(checksum), 64'd0);
      check("abort_writes_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      fill_random(1);
      run_load(1, 100, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
